axi4_wr_slave: RTL

AXI4 write-path slave that sits directly downstream of the `axi4_if` bundle. It terminates the AW, W and B channels of one master and converts each burst into per-beat word writes on a simple synchronous SRAM port. It supports FIXED, INCR and WRAP bursts and returns one B response per burst. One transaction is in flight at a time.

---
 rtl/axi4_pkg.sv | 30 +++
 rtl/axi4_addr_gen.sv | 31 +++
 rtl/axi4_wr_slave.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared AXI4 types and helpers for the write-path slave and the future
// read-path slave.
`timescale 1ns/1ps
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } wr_state_t;

    // WRAP bursts are legal only for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
`timescale 1ns/1ps
module axi4_addr_gen
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr      = addr + step;
        // Wrap window is (len+1) beats; only power-of-two lengths reach here legally.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            INCR:    next_addr = incr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi4_wr_slave.sv
// AXI4 write-path slave: one burst at a time, each beat becomes a registered
// word write on a simple SRAM port, one B response per burst.
`timescale 1ns/1ps
module axi4_wr_slave
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned WORD_SHIFT = $clog2(STRB_WIDTH);

    wr_state_t               state_q, state_d;
    logic                    awready_q, awready_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [7:0]              beat_q, beat_d;
    logic                    sup_q, sup_d;
    logic                    err_q, err_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    last_beat;
    logic                    size_err;
    logic                    wrap_err;
    logic                    cfg_err;
    logic                    range_err;
    logic                    wlast_err;
    logic [ADDR_WIDTH-1:0]   next_addr;

    axi4_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .addr     (addr_q),
        .size     (size_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_addr(next_addr)
    );

    assign aw_hs     = AWVALID && awready_q;
    assign w_hs      = WVALID && (state_q == DATA);
    assign last_beat = (beat_q == len_q);

    // Burst-level errors are decided once at AW capture and suppress every beat.
    assign size_err = AWSIZE > 3'(WORD_SHIFT);
    assign wrap_err = (AWBURST == WRAP) &&
                      (!wrap_len_ok(AWLEN) ||
                       ((AWADDR & ~({ADDR_WIDTH{1'b1}} << AWSIZE)) != '0));
    assign cfg_err  = (AWBURST == 2'b11) || size_err || wrap_err;

    // Beat-level errors: a word address beyond the SRAM drops only that beat.
    assign range_err = (addr_q >> (MEM_ADDR_WIDTH + WORD_SHIFT)) != '0;
    assign wlast_err = (WLAST != last_beat);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        sup_d       = sup_q;
        err_d       = err_q;
        bresp_d     = bresp_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        unique case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = AWID;
                    addr_d  = AWADDR;
                    len_d   = AWLEN;
                    size_d  = AWSIZE;
                    burst_d = AWBURST;
                    beat_d  = 8'd0;
                    sup_d   = cfg_err;
                    err_d   = cfg_err;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    mem_we_d    = !(sup_q || wlast_err || range_err);
                    mem_addr_d  = MEM_ADDR_WIDTH'(addr_q >> WORD_SHIFT);
                    mem_wdata_d = WDATA;
                    mem_wstrb_d = WSTRB;
                    addr_d      = next_addr;
                    beat_d      = beat_q + 8'd1;
                    sup_d       = sup_q || wlast_err;
                    err_d       = err_q || wlast_err || range_err;
                    if (last_beat) begin
                        bresp_d = (err_q || wlast_err || range_err) ? SLVERR : OKAY;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            awready_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            sup_q       <= 1'b0;
            err_q       <= 1'b0;
            bresp_q     <= OKAY;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            sup_q       <= sup_d;
            err_q       <= err_d;
            bresp_q     <= bresp_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = (state_q == DATA);
    assign BVALID    = (state_q == RESP);
    assign BID       = id_q;
    assign BRESP     = bresp_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
